epl_correlator: RTL
===================

EPL_CORRELATOR -- requirements
Module: epl_correlator

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 4, meaning the signed width of an input sample.
REQ-002 SHALL have parameter ACC_W, default 16, meaning the signed width of each accumulator.
REQ-003 SHALL have parameter EPOCH_SAMPLES, default 2046, meaning accepted samples per integration epoch (1023 chips x 2).
REQ-004 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-006 SHALL have port enable, input, 1, meaning run the correlator; low forces IDLE.
REQ-007 SHALL have port epoch_sync, input, 1, meaning restart the epoch on this cycle's sample.
REQ-008 SHALL have port sample_valid, input, 1, meaning sample_in and the chips are valid this cycle.
REQ-009 SHALL have port sample_in, input, SAMPLE_W signed, meaning the received baseband sample.
REQ-010 SHALL have ports chip_e, chip_p and chip_l, input, 1 each, meaning the early, punctual and late replica C/A chips.
REQ-011 SHALL have ports dump_e, dump_p and dump_l, output, ACC_W signed each, meaning the epoch correlation sums.
REQ-012 SHALL have port dump_valid, output, 1, meaning the dump_* outputs hold an unconsumed result.
REQ-013 SHALL have port dump_ready, input, 1, meaning the consumer accepts the dump when dump_valid is also high.
REQ-014 SHALL have port dump_lost, output, 1, a sticky flag meaning an epoch result was discarded.

Function
REQ-015 SHALL map chips bipolar: chip 0 gives +sample_in; chip 1 gives -sample_in.
REQ-016 SHALL update each arm's accumulator only on cycles with sample_valid high while in the ACCUM state.
REQ-017 SHALL perform sign-extended addition to ACC_W bits; wrap-around is not handled; ACC_W >= SAMPLE_W + clog2(EPOCH_SAMPLES) is a documented constraint.
REQ-018 SHALL implement a state machine with states IDLE and ACCUM.
REQ-019 SHALL move from IDLE to ACCUM on the first cycle with enable, sample_valid and epoch_sync all high; that sample SHALL be accumulated as sample 0.
REQ-020 SHALL move from ACCUM to IDLE when enable goes low; the accumulators and sample counter SHALL be cleared and no dump SHALL be produced.
REQ-021 SHALL count accepted samples from 0 to EPOCH_SAMPLES-1 with a sample counter.
REQ-022 SHALL, on the sample at count EPOCH_SAMPLES-1, load the three final sums (including that sample) into the dump registers on the next edge.
REQ-023 SHALL, on that same edge, restart the accumulators and counter at 0, so epochs are gapless.
REQ-024 SHALL, when epoch_sync arrives with sample_valid in ACCUM mid-epoch, discard the partial sums, assert no dump, and start a new epoch with that sample as sample 0.
REQ-025 SHALL give the dump a latency of one clock: dump_valid rises on the edge after the last epoch sample.
REQ-026 SHALL hold dump_valid high, with dump_* stable, until a cycle with dump_valid and dump_ready both high.
REQ-027 SHALL, when a new dump and the acceptance of the old dump occur in the same cycle, load the new dump and keep dump_valid high.
REQ-028 SHALL, when a new dump arrives while the previous dump is unaccepted, overwrite the previous dump with the new one and set dump_lost.
REQ-029 SHALL clear dump_lost only by reset.
REQ-030 SHALL give enable low no effect on a pending dump; dump_valid and dump_* are kept until accepted.

Reset
REQ-031 SHALL, on reset, set: state IDLE; accumulators 0; counter 0; dump_e, dump_p and dump_l 0; dump_valid 0; dump_lost 0.
REQ-032 SHALL, on reset asserted mid-epoch, discard all partial and pending results immediately, without waiting for a clock.

Structure
REQ-033 SHALL place the state enum and a dump record typedef (three ACC_W signed fields) in shared package gps_corr_pkg.
REQ-034 SHALL implement each arm as sub-module corr_arm, holding the bipolar multiply and accumulator, with a clear input and a load input; corr_arm is instantiated three times.

Verification
REQ-035 SHALL cover: sample_in=+3 for 2046 samples, all chips 0 -> dump_p=dump_e=dump_l=6138, dump_valid one cycle after the last sample.
REQ-036 SHALL cover: sample_in=+1, chip_p 0, chip_e=chip_l=1 -> dump_p=+2046, dump_e=dump_l=-2046.
REQ-037 SHALL cover: dump_ready held low across two epochs -> second dump values present, dump_lost=1; dump_valid falls after one ready cycle.
REQ-038 SHALL cover: dump_ready pulsed exactly on the cycle a new dump loads -> dump_valid stays 1, new values shown, dump_lost=0.
REQ-039 SHALL cover: epoch_sync at sample 500, then 2046 samples of +2 -> single dump of 4092, no dump for the partial epoch.
REQ-040 SHALL cover: enable dropped at sample 1000, then rst_n pulsed low mid-epoch -> no dump, and all outputs 0 immediately when rst_n falls.

Source files
------------

// File: rtl/gps_corr_pkg.sv
// Shared types for the early/punctual/late GPS correlator: FSM states and the
// dump record carried from the three accumulator arms to the output registers.
package gps_corr_pkg;

    // Width of each dump field; the correlator's ACC_W must match it.
    localparam int DUMP_W = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } corr_state_t;

    typedef struct packed {
        logic signed [DUMP_W-1:0] e;
        logic signed [DUMP_W-1:0] p;
        logic signed [DUMP_W-1:0] l;
    } dump_t;

endpackage

// File: rtl/corr_arm.sv
// One correlator arm: bipolar chip multiply (0 -> +sample, 1 -> -sample) and a
// signed accumulator. sum is the running total including this cycle's sample.
module corr_arm #(
    parameter int SAMPLE_W = 4,
    parameter int ACC_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       load,
    input  logic                       add,
    input  logic                       chip,
    input  logic signed [SAMPLE_W-1:0] sample,
    output logic signed [ACC_W-1:0]    sum
);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sample_ext;
    logic signed [ACC_W-1:0] term;

    assign sample_ext = {{(ACC_W - SAMPLE_W){sample[SAMPLE_W-1]}}, sample};
    assign term       = chip ? -sample_ext : sample_ext;
    assign sum        = acc + term;

    // load starts a fresh epoch with this sample as sample 0; clear wins over both.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (load) begin
            acc <= term;
        end else if (add) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/epl_correlator.sv
// Early/punctual/late correlator: integrates EPOCH_SAMPLES accepted samples per
// epoch into three arms and presents the sums through a valid/ready dump register.
module epl_correlator
    import gps_corr_pkg::*;
#(
    parameter int SAMPLE_W      = 4,
    parameter int ACC_W         = 16,
    parameter int EPOCH_SAMPLES = 2046
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       epoch_sync,
    input  logic                       sample_valid,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       chip_e,
    input  logic                       chip_p,
    input  logic                       chip_l,
    output logic signed [ACC_W-1:0]    dump_e,
    output logic signed [ACC_W-1:0]    dump_p,
    output logic signed [ACC_W-1:0]    dump_l,
    output logic                       dump_valid,
    input  logic                       dump_ready,
    output logic                       dump_lost
);

    localparam int              CNT_W = $clog2(EPOCH_SAMPLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(EPOCH_SAMPLES - 1);

    corr_state_t             state;
    logic [CNT_W-1:0]        cnt;
    dump_t                   dump_q;
    logic                    arm_clear, arm_load, arm_add, epoch_end;
    logic signed [ACC_W-1:0] sum_e, sum_p, sum_l;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        arm_clear = 1'b0;
        arm_load  = 1'b0;
        arm_add   = 1'b0;
        epoch_end = 1'b0;
        case (state)
            IDLE:  arm_load = enable && sample_valid && epoch_sync;
            ACCUM: begin
                if (!enable) begin
                    arm_clear = 1'b1;
                end else if (sample_valid) begin
                    if (epoch_sync) begin
                        arm_load = 1'b1;
                    end else if (cnt == LAST) begin
                        epoch_end = 1'b1;
                        arm_clear = 1'b1;
                    end else begin
                        arm_add = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    corr_arm #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) u_arm_e (
        .clk(clk), .rst_n(rst_n), .clear(arm_clear), .load(arm_load), .add(arm_add),
        .chip(chip_e), .sample(sample_in), .sum(sum_e)
    );
    corr_arm #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) u_arm_p (
        .clk(clk), .rst_n(rst_n), .clear(arm_clear), .load(arm_load), .add(arm_add),
        .chip(chip_p), .sample(sample_in), .sum(sum_p)
    );
    corr_arm #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) u_arm_l (
        .clk(clk), .rst_n(rst_n), .clear(arm_clear), .load(arm_load), .add(arm_add),
        .chip(chip_l), .sample(sample_in), .sum(sum_l)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (arm_load) begin
                    state <= ACCUM;
                    cnt   <= CNT_W'(1);
                end
                ACCUM: begin
                    if (!enable) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (arm_load) begin
                        cnt <= CNT_W'(1);
                    end else if (epoch_end) begin
                        cnt <= '0;
                    end else if (arm_add) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A new dump always loads; it counts as lost only if the old one was not taken this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dump_q     <= '0;
            dump_valid <= 1'b0;
            dump_lost  <= 1'b0;
        end else if (epoch_end) begin
            dump_q     <= '{e: sum_e, p: sum_p, l: sum_l};
            dump_valid <= 1'b1;
            if (dump_valid && !dump_ready) begin
                dump_lost <= 1'b1;
            end
        end else if (dump_valid && dump_ready) begin
            dump_valid <= 1'b0;
        end
    end

    assign dump_e = dump_q.e;
    assign dump_p = dump_q.p;
    assign dump_l = dump_q.l;

endmodule
